conv_filter_kxk: RTL
====================

CONV_FILTER_KXK -- requirements
Module: conv_filter_kxk

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 720: frame width in pixels.
REQ-003 SHALL have parameter IMG_H, default 540: frame height in pixels.
REQ-004 SHALL have parameter KSIZE, default 5: kernel size; legal values 3 or 5.
REQ-005 SHALL have port clock  input  1: clock; reset  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port mode  input  2: 00 gaussian, 01 box, 10 bypass, 11 reserved (treated as bypass).
REQ-007 SHALL have ports in_rd_en  output  1 and in_empty  input  1: input FIFO read strobe and empty flag.
REQ-008 SHALL have port in_dout  input  PIX_W: input pixel, valid in the same cycle as in_rd_en.
REQ-009 SHALL have ports out_wr_en  output  1 and out_full  input  1: output FIFO write strobe and full flag.
REQ-010 SHALL have port out_din  output  PIX_W: filtered pixel.
REQ-011 SHALL have port frame_done  output  1: one-cycle pulse with the last output pixel of a frame.

Function
REQ-012 SHALL process raster-order frames and emit exactly IMG_W*IMG_H outputs per frame, one per input pixel, in raster order.
REQ-013 SHALL hold a window buffer of (KSIZE-1)*IMG_W+KSIZE pixels, shifting one pixel per accepted input or flush step.
REQ-014 SHALL implement FSM FILL -> RUN -> FLUSH -> FILL; FILL reads the first (KSIZE/2)*IMG_W+KSIZE/2 pixels without output; RUN outputs one pixel per input; FLUSH shifts zeros without reading until the frame's last output is written.
REQ-015 SHALL sample mode at the first read of each frame and hold it for the whole frame.
REQ-016 SHALL compute out = sum(pixel*coef)/sum(coef) over in-image taps only; out-of-image taps are excluded from numerator and denominator.
REQ-017 Kernels: gaussian 5x5 rows {2,4,5,4,2},{4,9,12,9,4},{5,12,15,12,5},{4,9,12,9,4},{2,4,5,4,2}; gaussian 3x3 {1,2,1},{2,4,2},{1,2,1}; box is all ones.
REQ-018 SHALL size the numerator at PIX_W+8 bits and the denominator at 8 bits, and saturate the quotient to 2^PIX_W-1.
REQ-019 Bypass SHALL output the window-centre pixel unchanged, with the same latency and count as filtering.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers the MAC and denominator; stage 2 registers the divide. Sustained throughput is 1 pixel/clock when not stalled.
REQ-021 out_full=1 SHALL freeze the window, pipeline and counters; in_rd_en=0 while stalled; no pixel is lost or duplicated.
REQ-022 in_empty=1 during FILL/RUN SHALL insert a bubble: no shift and no output advance.
REQ-023 The column counter SHALL wrap at IMG_W-1 and increment the row; the row counter SHALL wrap at IMG_H-1 with frame_done.
REQ-024 A new frame's reads SHALL begin in the cycle after frame_done, with no idle gap required.

Reset
REQ-025 Reset SHALL clear the FSM to FILL, all counters, the window, and the pipeline valid bits; in_rd_en, out_wr_en, frame_done and out_din read 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the next pixel read is treated as pixel (0,0).

Configuration
REQ-027 With macro CONV_ROUND_EN defined, the divide SHALL round half up: (num + den/2)/den. Without it, the divide SHALL truncate.

Structure
REQ-028 Package filter_pkg SHALL hold the mode enum, the kernel coefficient tables, and the width helper constants.
REQ-029 The window storage SHALL be sub-module line_window (parameters PIX_W, IMG_W, KSIZE; shift enable, pixel in, KSIZE*KSIZE tap outputs).

Verification
REQ-030 IMG 8x6, KSIZE 5, gaussian, all pixels 100 -> 48 outputs, all 100, including borders; frame_done on output 48.
REQ-031 IMG 8x6, gaussian, single 255 at (3,3), else 0 -> out(3,3)=24 (255*15/159); out(3,4)=19 (255*12/159); ROUND_EN unchanged for these values.
REQ-032 mode=10, ramp 0..47 -> outputs 0..47 in order; first out_wr_en after 2*8+2 reads.
REQ-033 out_full held 20 cycles mid-RUN -> in_rd_en low for the hold; output sequence identical to the unstalled run.
REQ-034 Reset asserted after 30 reads, then a fresh constant-100 frame -> exactly 48 outputs of 100.
REQ-035 Two back-to-back frames, box then gaussian with mode changed mid-frame 1 -> frame 1 is all box; 2 frame_done pulses; 96 outputs.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the KxK convolution filter.
//   mode_e      : per-frame filter selection (gaussian, box, bypass, reserved)
//   state_e     : frame sequencer states
//   kernel_coef : coefficient lookup for a tap, given kernel size and mode
//   win_len     : window buffer depth for a kernel size and frame width
//   cnt_w       : counter width able to hold 0..n-1
package filter_pkg;

  typedef enum logic [1:0] {
    ModeGauss  = 2'b00,
    ModeBox    = 2'b01,
    ModeBypass = 2'b10,
    ModeRsvd   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StFlush
  } state_e;

  localparam int unsigned CoefW     = 8;
  localparam int unsigned DenW      = 8;
  localparam int unsigned MacExtraW = 8;

  localparam logic [CoefW-1:0] Gauss5 [5][5] = '{
    '{8'd2, 8'd4,  8'd5,  8'd4,  8'd2},
    '{8'd4, 8'd9,  8'd12, 8'd9,  8'd4},
    '{8'd5, 8'd12, 8'd15, 8'd12, 8'd5},
    '{8'd4, 8'd9,  8'd12, 8'd9,  8'd4},
    '{8'd2, 8'd4,  8'd5,  8'd4,  8'd2}
  };

  localparam logic [CoefW-1:0] Gauss3 [3][3] = '{
    '{8'd1, 8'd2, 8'd1},
    '{8'd2, 8'd4, 8'd2},
    '{8'd1, 8'd2, 8'd1}
  };

  function automatic logic [CoefW-1:0] kernel_coef(input int unsigned ksize, input mode_e mode,
                                                   input int unsigned r, input int unsigned c);
    if (mode == ModeBox) return 8'd1;
    // Modulo keeps the 3x3 index in range when this branch is elaborated for a 5x5 kernel.
    if (ksize == 3) return Gauss3[r % 3][c % 3];
    return Gauss5[r % 5][c % 5];
  endfunction

  function automatic int unsigned win_len(input int unsigned ksize, input int unsigned img_w);
    return (ksize - 1) * img_w + ksize;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_window.sv
// Sliding raster window: a shift register of (KSIZE-1)*IMG_W+KSIZE pixels.
// The newest pixel enters at index 0; the KSIZE*KSIZE taps are picked out so
// that tap (r,c) sits at taps[(r*KSIZE+c)*PIX_W +: PIX_W], row 0 / col 0 being
// the oldest (top-left) pixel of the window.
// Ports:
//   clock, reset : clock, asynchronous active-high reset (clears the window)
//   shift        : advance the window by one pixel
//   pix_in       : pixel shifted in
//   taps         : flattened KSIZE*KSIZE tap outputs
module line_window
  import filter_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 720,
  parameter int unsigned KSIZE = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           shift,
  input  logic [PIX_W-1:0]               pix_in,
  output logic [KSIZE*KSIZE*PIX_W-1:0]   taps
);

  localparam int unsigned Len = win_len(KSIZE, IMG_W);

  logic [PIX_W-1:0] win_q [Len];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Len; i++) win_q[i] <= '0;
    end else if (shift) begin
      win_q[0] <= pix_in;
      for (int i = 1; i < Len; i++) win_q[i] <= win_q[i-1];
    end
  end

  always_comb begin
    taps = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        taps[(r*KSIZE+c)*PIX_W +: PIX_W] = win_q[(KSIZE-1-r)*IMG_W + (KSIZE-1-c)];
      end
    end
  end

endmodule

// File: rtl/conv_filter_kxk.sv
// KxK normalised convolution filter between two FIFOs, raster order.
// Each output is sum(pixel*coef)/sum(coef) over the taps that fall inside the
// image; bypass returns the window-centre pixel. Mode is latched at the first
// read of a frame. Pipeline: window -> MAC/denominator register -> divide register.
// Build option: define CONV_ROUND_EN to round the divide half up (default truncates).
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   mode                  : 00 gaussian, 01 box, 10/11 bypass
//   in_rd_en/in_empty     : input FIFO read strobe / empty flag
//   in_dout               : input pixel (valid with in_rd_en)
//   out_wr_en/out_full    : output FIFO write strobe / full flag
//   out_din               : filtered pixel
//   frame_done            : pulse with the last output pixel of a frame
module conv_filter_kxk
  import filter_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 720,
  parameter int unsigned IMG_H = 540,
  parameter int unsigned KSIZE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] out_din,
  output logic             frame_done
);

  localparam int unsigned Half  = KSIZE / 2;
  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned FillN = Half * IMG_W + Half;
  localparam int unsigned NumW  = PIX_W + MacExtraW;
  localparam int unsigned NumXW = NumW + 1;
  localparam int unsigned CntW  = cnt_w(NPix + 1);
  localparam int unsigned FlW   = cnt_w(FillN + 1);
  localparam int unsigned ColW  = cnt_w(IMG_W);
  localparam int unsigned RowW  = cnt_w(IMG_H);
  localparam logic [PIX_W-1:0] PixMax = '1;

  state_e          state_q, state_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [FlW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  mode_e           mode_q, mode_d;

  logic rd, flush_shift, out_shift, last_px, stall;

  // Window stage: the centre pixel that entered on the previous shift.
  logic            w_valid_q, w_last_q;
  logic [ColW-1:0] w_col_q;
  logic [RowW-1:0] w_row_q;

  logic             s1_valid_q, s1_last_q, s1_bypass_q;
  logic [NumW-1:0]  s1_num_q;
  logic [DenW-1:0]  s1_den_q;
  logic [PIX_W-1:0] s1_ctr_q;

  logic             s2_valid_q, s2_last_q;
  logic [PIX_W-1:0] s2_pix_q;

  logic [KSIZE*KSIZE*PIX_W-1:0] taps;
  logic [NumW-1:0]  mac_num;
  logic [DenW-1:0]  mac_den;
  logic [PIX_W-1:0] centre;
  logic [NumXW-1:0] num_adj, quot_full;
  logic [PIX_W-1:0] quot;

  assign stall      = out_full;
  assign out_wr_en  = s2_valid_q & ~out_full;
  assign frame_done = out_wr_en & s2_last_q;
  assign out_din    = s2_pix_q;
  assign in_rd_en   = rd & ~reset;
  assign centre     = taps[(Half*KSIZE+Half)*PIX_W +: PIX_W];
  assign last_px    = (col_q == ColW'(IMG_W - 1)) && (row_q == RowW'(IMG_H - 1));

  line_window #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .KSIZE (KSIZE)
  ) u_window (
    .clock  (clock),
    .reset  (reset),
    .shift  (rd | flush_shift),
    .pix_in (flush_shift ? '0 : in_dout),
    .taps   (taps)
  );

  // Sequencer and counters.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    mode_d      = mode_q;
    col_d       = col_q;
    row_d       = row_q;
    rd          = 1'b0;
    flush_shift = 1'b0;
    out_shift   = 1'b0;
    unique case (state_q)
      StFill: begin
        rd = ~stall & ~in_empty;
        if (rd) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == '0) mode_d = mode_e'(mode);
          if (rd_cnt_q == CntW'(FillN - 1)) state_d = StRun;
        end
      end
      StRun: begin
        rd        = ~stall & ~in_empty;
        out_shift = rd;
        if (rd) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == CntW'(NPix - 1)) begin
            state_d  = StFlush;
            fl_cnt_d = '0;
          end
        end
      end
      StFlush: begin
        flush_shift = ~stall & (fl_cnt_q != FlW'(FillN));
        out_shift   = flush_shift;
        if (flush_shift) fl_cnt_d = fl_cnt_q + 1'b1;
        // Hold off the next frame until the last pixel has left the pipeline.
        if (frame_done) begin
          state_d  = StFill;
          rd_cnt_d = '0;
        end
      end
      default: state_d = StFill;
    endcase

    if (out_shift) begin
      if (col_q == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StFill;
      rd_cnt_q <= '0;
      fl_cnt_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= ModeGauss;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
    end
  end

  // Masked MAC: taps outside the image contribute to neither sum.
  always_comb begin
    int ty, tx;
    logic [CoefW-1:0] coef;
    mac_num = '0;
    mac_den = '0;
    ty      = 0;
    tx      = 0;
    coef    = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        ty = int'(w_row_q) + r - int'(Half);
        tx = int'(w_col_q) + c - int'(Half);
        if (ty >= 0 && ty < int'(IMG_H) && tx >= 0 && tx < int'(IMG_W)) begin
          coef    = kernel_coef(KSIZE, mode_q, r, c);
          mac_num = mac_num + NumW'(taps[(r*KSIZE+c)*PIX_W +: PIX_W]) * NumW'(coef);
          mac_den = mac_den + coef;
        end
      end
    end
  end

  always_comb begin
`ifdef CONV_ROUND_EN
    num_adj = {1'b0, s1_num_q} + NumXW'(s1_den_q >> 1);
`else
    num_adj = {1'b0, s1_num_q};
`endif
    quot_full = '0;
    if (s1_den_q != '0) quot_full = num_adj / NumXW'(s1_den_q);
    if (s1_bypass_q) quot = s1_ctr_q;
    else if (quot_full > NumXW'(PixMax)) quot = PixMax;
    else quot = quot_full[PIX_W-1:0];
  end

  // Whole pipeline freezes while the output FIFO is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      w_col_q     <= '0;
      w_row_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_bypass_q <= 1'b0;
      s1_num_q    <= '0;
      s1_den_q    <= '0;
      s1_ctr_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_pix_q    <= '0;
    end else if (!stall) begin
      w_valid_q <= out_shift;
      if (out_shift) begin
        w_last_q <= last_px;
        w_col_q  <= col_q;
        w_row_q  <= row_q;
      end
      s1_valid_q  <= w_valid_q;
      s1_last_q   <= w_last_q;
      s1_bypass_q <= (mode_q == ModeBypass) || (mode_q == ModeRsvd);
      s1_num_q    <= mac_num;
      s1_den_q    <= mac_den;
      s1_ctr_q    <= centre;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_pix_q    <= quot;
    end
  end

endmodule
